aes_avalon_master: RTL and testbench

- Avalon-MM master that drives the AES decryption core's register-mapped slave from a local command port.
- Writes a 128-bit key and a 128-bit encrypted message, sets the start register, then polls the done register.
- Reads back the 128-bit decrypted message and returns it to the requester.
- Sits between a local controller (or test harness) and the AES slave's Avalon-MM port.

---
 rtl/aes_master_pkg.sv | 42 ++++
 rtl/avm_cmd_reg.sv | 32 +++
 rtl/aes_avalon_master.sv | 217 +++++++++++++++++++++
 tb/tb_aes_avalon_master.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_master_pkg.sv
// Shared types and register map for the AES Avalon-MM master.
// AES_MASTER_CLEAR_START_EN adds the CLR_START state that rewrites the start register to 0.
package aes_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_KEY,
        ST_WR_MSG,
        ST_WR_START,
        ST_POLL,
        ST_RD_RESULT,
`ifdef AES_MASTER_CLEAR_START_EN
        ST_CLR_START,
`endif
        ST_FINISH
    } state_e;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } avm_cmd_t;

    localparam logic [3:0]  KEY_BASE   = 4'd0;
    localparam logic [3:0]  MSG_BASE   = 4'd4;
    localparam logic [3:0]  RES_BASE   = 4'd8;
    localparam logic [3:0]  START_ADDR = 4'd14;
    localparam logic [3:0]  DONE_ADDR  = 4'd15;
    localparam logic [31:0] START_VAL  = 32'h1;

    // Word 0 is the most significant 32 bits of the 128-bit block.
    function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    word_sel = v[127:96];
            2'd1:    word_sel = v[95:64];
            2'd2:    word_sel = v[63:32];
            default: word_sel = v[31:0];
        endcase
    endfunction

endpackage

// File: rtl/avm_cmd_reg.sv
// Avalon-MM command register: holds the issued command stable while the slave stalls
// and reports when the current command is accepted.
module avm_cmd_reg
    import aes_master_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  avm_cmd_t cmd_i,
    input  logic     waitrequest_i,
    output avm_cmd_t cmd_o,
    output logic     accept_o
);

    avm_cmd_t cmd_q;
    logic     active_s;

    assign active_s = cmd_q.read | cmd_q.write;
    assign accept_o = active_s & ~waitrequest_i;
    assign cmd_o    = cmd_q;

    // A new command is taken only when the bus is free or the current one completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q <= '0;
        end else if (!active_s || accept_o) begin
            cmd_q <= cmd_i;
        end else begin
            cmd_q <= cmd_q;
        end
    end

endmodule

// File: rtl/aes_avalon_master.sv
// Avalon-MM master sequencing key/message writes, start, done polling and result reads
// on an AES decryption slave. AES_MASTER_CLEAR_START_EN enables the trailing start-clear write.
module aes_avalon_master
    import aes_master_pkg::*;
#(
    parameter int POLL_LIMIT = 1024,
    parameter int PCW        = 11
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         START,
    input  logic [127:0] KEY,
    input  logic [127:0] MSG,
    output logic [127:0] RESULT,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR,
    output logic         AVM_READ,
    output logic         AVM_WRITE,
    output logic         AVM_CS,
    output logic [3:0]   AVM_BYTE_EN,
    output logic [3:0]   AVM_ADDR,
    output logic [31:0]  AVM_WRITEDATA,
    input  logic [31:0]  AVM_READDATA,
    input  logic         AVM_WAITREQUEST
);

    localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_LIMIT);

    state_e         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [PCW-1:0] poll_q, poll_d;
    logic [127:0]   key_q, key_d, msg_q, msg_d, result_q, result_d;
    logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
    avm_cmd_t       cmd_s, bus_s;
    logic           accept_s;

    avm_cmd_reg u_cmd (
        .clk_i         (CLK),
        .rst_ni        (RESET_N),
        .cmd_i         (cmd_s),
        .waitrequest_i (AVM_WAITREQUEST),
        .cmd_o         (bus_s),
        .accept_o      (accept_s)
    );

    // Next-state sequencing and the command to present after this edge.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        poll_d   = poll_q;
        key_d    = key_q;
        msg_d    = msg_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cmd_s    = '0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    key_d   = KEY;
                    msg_d   = MSG;
                    idx_d   = 2'd0;
                    poll_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_WR_KEY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_KEY: begin
                if (accept_s) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = ST_WR_MSG;
                    else               state_d = ST_WR_KEY;
                end
            end
            ST_WR_MSG: begin
                if (accept_s) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = ST_WR_START;
                    else               state_d = ST_WR_MSG;
                end
            end
            ST_WR_START: begin
                if (accept_s) state_d = ST_POLL;
                else          state_d = ST_WR_START;
            end
            ST_POLL: begin
                if (accept_s) begin
                    if (AVM_READDATA[0]) begin
                        state_d = ST_RD_RESULT;
                    end else begin
                        poll_d = poll_q + {{(PCW-1){1'b0}}, 1'b1};
                        if (poll_d == POLL_MAX) begin
                            state_d = ST_FINISH;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_POLL;
                        end
                    end
                end
            end
            ST_RD_RESULT: begin
                if (accept_s) begin
                    case (idx_q)
                        2'd0:    result_d[127:96] = AVM_READDATA;
                        2'd1:    result_d[95:64]  = AVM_READDATA;
                        2'd2:    result_d[63:32]  = AVM_READDATA;
                        default: result_d[31:0]   = AVM_READDATA;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
`ifdef AES_MASTER_CLEAR_START_EN
                        state_d = ST_CLR_START;
`else
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_RD_RESULT;
                    end
                end
            end
`ifdef AES_MASTER_CLEAR_START_EN
            ST_CLR_START: begin
                if (accept_s) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_CLR_START;
                end
            end
`endif
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // The command register only samples this when the bus is free or just accepted.
        case (state_d)
            ST_WR_KEY: begin
                cmd_s.write = 1'b1;
                cmd_s.addr  = KEY_BASE + {2'b00, idx_d};
                cmd_s.wdata = word_sel(key_d, idx_d);
            end
            ST_WR_MSG: begin
                cmd_s.write = 1'b1;
                cmd_s.addr  = MSG_BASE + {2'b00, idx_d};
                cmd_s.wdata = word_sel(msg_d, idx_d);
            end
            ST_WR_START: begin
                cmd_s.write = 1'b1;
                cmd_s.addr  = START_ADDR;
                cmd_s.wdata = START_VAL;
            end
            ST_POLL: begin
                cmd_s.read = 1'b1;
                cmd_s.addr = DONE_ADDR;
            end
            ST_RD_RESULT: begin
                cmd_s.read = 1'b1;
                cmd_s.addr = RES_BASE + {2'b00, idx_d};
            end
`ifdef AES_MASTER_CLEAR_START_EN
            ST_CLR_START: begin
                cmd_s.write = 1'b1;
                cmd_s.addr  = START_ADDR;
                cmd_s.wdata = 32'h0;
            end
`endif
            default: cmd_s = '0;
        endcase
    end

    // Architectural state and status outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            poll_q   <= '0;
            key_q    <= 128'h0;
            msg_q    <= 128'h0;
            result_q <= 128'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            poll_q   <= poll_d;
            key_q    <= key_d;
            msg_q    <= msg_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign RESULT        = result_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERR           = err_q;
    assign AVM_READ      = bus_s.read;
    assign AVM_WRITE     = bus_s.write;
    assign AVM_CS        = bus_s.read | bus_s.write;
    assign AVM_BYTE_EN   = (bus_s.read | bus_s.write) ? 4'hF : 4'h0;
    assign AVM_ADDR      = bus_s.addr;
    assign AVM_WRITEDATA = bus_s.wdata;

endmodule

// File: tb/tb_aes_avalon_master.sv
// Directed bench for aes_avalon_master against a small AES-slave register model.
module tb_aes_avalon_master;

    localparam int TB_POLL_LIMIT = 8;
`ifdef AES_MASTER_CLEAR_START_EN
    localparam int LAT0 = 16;
    localparam int NACC = 15;
`else
    localparam int LAT0 = 15;
    localparam int NACC = 14;
`endif

    logic         CLK = 1'b0;
    logic         RESET_N, START;
    logic [127:0] KEY, MSG, RESULT;
    logic         BUSY, DONE, ERR, AVM_READ, AVM_WRITE, AVM_CS, AVM_WAITREQUEST;
    logic [3:0]   AVM_BYTE_EN, AVM_ADDR;
    logic [31:0]  AVM_WRITEDATA, AVM_READDATA;

    int checks = 0;
    int errors = 0;

    aes_avalon_master #(.POLL_LIMIT(TB_POLL_LIMIT), .PCW(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .KEY(KEY), .MSG(MSG),
        .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .AVM_READ(AVM_READ), .AVM_WRITE(AVM_WRITE), .AVM_CS(AVM_CS),
        .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_ADDR(AVM_ADDR), .AVM_WRITEDATA(AVM_WRITEDATA),
        .AVM_READDATA(AVM_READDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST)
    );

    always #5 CLK = ~CLK;

    // Slave model state
    int           stall_n    = 0;
    int           done_after = 1;
    logic [127:0] slave_res  = 128'h0;
    int           stall_cnt  = 0;
    int           poll_seen  = 0;
    int           log_n      = 0;
    int           stable_err = 0;
    int           proto_err  = 0;
    logic         hold_pend  = 1'b0;
    logic [37:0]  snap       = 38'h0;
    logic         log_we   [1024];
    logic [3:0]   log_addr [1024];
    logic [31:0]  log_data [1024];
    logic [173:0] outs_s;

    assign outs_s = {RESULT, BUSY, DONE, ERR, AVM_READ, AVM_WRITE, AVM_CS,
                     AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA};
    assign AVM_WAITREQUEST = AVM_CS && (stall_cnt < stall_n);

    always_comb begin
        AVM_READDATA = 32'hBAD0_0000;
        case (AVM_ADDR)
            4'd8:  AVM_READDATA = slave_res[127:96];
            4'd9:  AVM_READDATA = slave_res[95:64];
            4'd10: AVM_READDATA = slave_res[63:32];
            4'd11: AVM_READDATA = slave_res[31:0];
            4'd15: AVM_READDATA = {31'd0, (done_after != 0) && (poll_seen + 1 >= done_after)};
            default: AVM_READDATA = 32'hBAD0_0000;
        endcase
    end

    always @(posedge CLK) begin
        if (AVM_CS !== (AVM_READ | AVM_WRITE) || (AVM_READ && AVM_WRITE) ||
            AVM_BYTE_EN !== (AVM_CS ? 4'hF : 4'h0))
            proto_err <= proto_err + 1;
        if (!RESET_N) begin
            stall_cnt <= 0;
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend && {AVM_READ, AVM_WRITE, AVM_ADDR, AVM_WRITEDATA} !== snap)
                stable_err <= stable_err + 1;
            if (AVM_CS && AVM_WAITREQUEST) begin
                hold_pend <= 1'b1;
                snap      <= {AVM_READ, AVM_WRITE, AVM_ADDR, AVM_WRITEDATA};
                stall_cnt <= stall_cnt + 1;
            end else begin
                hold_pend <= 1'b0;
                stall_cnt <= 0;
            end
            if (AVM_CS && !AVM_WAITREQUEST && log_n < 1024) begin
                log_we[log_n]   <= AVM_WRITE;
                log_addr[log_n] <= AVM_ADDR;
                log_data[log_n] <= AVM_WRITE ? AVM_WRITEDATA : AVM_READDATA;
                log_n           <= log_n + 1;
                if (AVM_WRITE && AVM_ADDR == 4'd14 && AVM_WRITEDATA == 32'h1)
                    poll_seen <= 0;
                else if (AVM_READ && AVM_ADDR == 4'd15)
                    poll_seen <= poll_seen + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [127:0] v, input int j);
        return v[127 - 32*j -: 32];
    endfunction

    task automatic exp_acc(input int idx, input logic we, input logic [3:0] a, input logic [31:0] d);
        check_val($sformatf("acc%0d", idx), {log_we[idx], log_addr[idx], log_data[idx]}, {we, a, d});
    endtask

    // Expected bus trace for one operation starting at log index base.
    task automatic check_seq(input int base, input logic [127:0] k, input logic [127:0] m,
                             input logic [127:0] res, input int polls, input bit timeout);
        int i = base;
        for (int j = 0; j < 4; j++) begin exp_acc(i, 1'b1, 4'(j), wd(k, j)); i++; end
        for (int j = 0; j < 4; j++) begin exp_acc(i, 1'b1, 4'(4 + j), wd(m, j)); i++; end
        exp_acc(i, 1'b1, 4'd14, 32'h1); i++;
        for (int p = 1; p <= polls; p++) begin
            exp_acc(i, 1'b0, 4'd15, {31'd0, (!timeout && p == polls)}); i++;
        end
        if (!timeout) begin
            for (int j = 0; j < 4; j++) begin exp_acc(i, 1'b0, 4'(8 + j), wd(res, j)); i++; end
`ifdef AES_MASTER_CLEAR_START_EN
            exp_acc(i, 1'b1, 4'd14, 32'h0); i++;
`endif
        end
        check_val("acc_count", 256'(log_n - base), 256'(i - base));
    endtask

    // Pulse START, optionally re-pulse it at cycle extra_at, wait (bounded) for DONE.
    task automatic run_op(input logic [127:0] k, input logic [127:0] m, input int extra_at,
                          output int lat);
        @(negedge CLK);
        START = 1'b1; KEY = k; MSG = m;
        lat = 0;
        while (lat < 3000) begin
            @(negedge CLK);
            lat++;
            START = (lat == extra_at);
            KEY   = ~k;
            MSG   = ~m;
            if (DONE) break;
        end
        START = 1'b0;
        check_val("done_seen", DONE, 1'b1);
    endtask

    initial begin
        int lat, base, found;
        logic [127:0] k1, m1, r1, r2, r3;
        k1 = 128'h000102030405060708090a0b0c0d0e0f;
        m1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        r1 = 128'h00112233445566778899aabbccddeeff;
        r2 = 128'hcafef00d_12345678_9abcdef0_0badc0de;
        r3 = 128'hfedcba98_76543210_01234567_89abcdef;
        RESET_N = 1'b0; START = 1'b0; KEY = 128'h0; MSG = 128'h0;
        repeat (3) @(negedge CLK);
        check_val("reset_outs", outs_s, 174'h0);
        RESET_N = 1'b1;
        @(negedge CLK);
        check_val("idle_busy", BUSY, 1'b0);

        // Zero-wait, done on first poll
        slave_res = r1; done_after = 1; base = log_n;
        run_op(k1, m1, 0, lat);
        check_val("lat_basic", 256'(lat), 256'(LAT0));
        check_val("err_basic", ERR, 1'b0);
        check_val("res_basic", RESULT, r1);
        check_val("busy_done", BUSY, 1'b0);
        check_seq(base, k1, m1, r1, 1, 1'b0);
        @(negedge CLK);
        check_val("done_pulse", DONE, 1'b0);

        // Three wait states on every access
        stall_n = 3; slave_res = r2; base = log_n;
        run_op(m1, k1, 0, lat);
        check_val("lat_stall", 256'(lat), 256'(LAT0 + 3 * NACC));
        check_val("res_stall", RESULT, r2);
        check_seq(base, m1, k1, r2, 1, 1'b0);
        stall_n = 0;

        // Done after seven polls
        done_after = 7; slave_res = r3; base = log_n;
        run_op(k1, ~m1, 0, lat);
        check_val("lat_poll7", 256'(lat), 256'(LAT0 + 6));
        check_val("err_poll7", ERR, 1'b0);
        check_val("res_poll7", RESULT, r3);
        check_seq(base, k1, ~m1, r3, 7, 1'b0);

        // Timeout: done never set, RESULT must keep r3
        done_after = 0; slave_res = r1; base = log_n;
        run_op(~k1, m1, 0, lat);
        check_val("lat_tmo", 256'(lat), 256'(9 + TB_POLL_LIMIT + 1));
        check_val("err_tmo", ERR, 1'b1);
        check_val("res_tmo", RESULT, r3);
        check_seq(base, ~k1, m1, r1, TB_POLL_LIMIT, 1'b1);

        // Reset while MSG word 2 is on the bus
        done_after = 1; slave_res = r2;
        @(negedge CLK);
        START = 1'b1; KEY = k1; MSG = m1;
        @(negedge CLK);
        START = 1'b0;
        found = 0;
        for (int c = 0; c < 50; c++) begin
            if (AVM_WRITE && AVM_ADDR == 4'd6) begin found = 1; break; end
            @(negedge CLK);
        end
        check_val("msg2_reached", 256'(found), 256'(1));
        RESET_N = 1'b0;
        #1;
        check_val("midrst_outs", outs_s, 174'h0);
        base = log_n;
        check_val("midrst_last", log_addr[log_n - 1], 4'd5);
        repeat (3) @(negedge CLK);
        check_val("midrst_quiet", 256'(log_n), 256'(base));
        RESET_N = 1'b1;
        run_op(k1, m1, 0, lat);
        check_val("lat_after_rst", 256'(lat), 256'(LAT0));
        check_val("res_after_rst", RESULT, r2);
        check_seq(base, k1, m1, r2, 1, 1'b0);

        // Second START while busy is ignored
        slave_res = r3; base = log_n;
        run_op(m1, k1, 5, lat);
        check_val("lat_dup_start", 256'(lat), 256'(LAT0));
        check_val("res_dup_start", RESULT, r3);
        check_seq(base, m1, k1, r3, 1, 1'b0);
        repeat (3) @(negedge CLK);
        check_val("dup_no_rerun", 256'(log_n - base), 256'(NACC));

        check_val("bus_stable", 256'(stable_err), 256'(0));
        check_val("bus_proto", 256'(proto_err), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
